// File: rtl/bus_cycle_ctrl.sv
// 68000 bus cycle sequencer: enables memmap, samples its one-hot chip selects,
// inserts per-region wait states and terminates with DTACK or BERR.
module bus_cycle_ctrl #(
  parameter int unsigned ROM_WAIT  = 2,
  parameter int unsigned RAM_WAIT  = 1,
  parameter int unsigned IO_WAIT   = 4,
  parameter int unsigned GFX_WAIT  = 3,
  parameter int unsigned CTRL_WAIT = 0,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       as_n,
  input  logic       uds_n,
  input  logic       lds_n,
  input  logic [7:0] cs_in,
  input  logic       io_ready_n,
  output logic       map_enable,
  output logic       dtack_n,
  output logic       berr_n,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_FAULT
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_wait, w_wait_next;
  logic [7:0] r_tmo, w_tmo_next;
  logic       r_is_io, w_is_io_next;
  logic       w_start;
  logic       w_timeout;
  logic       w_region_ok;
  logic [7:0] w_sel_wait;

  assign w_start   = !as_n && (!uds_n || !lds_n);
  assign w_timeout = (r_tmo == 8'(TIMEOUT - 1));

  // Only exact one-hot selects of bits 7..1 are legal; everything else faults.
  always_comb begin
    w_region_ok = 1'b1;
    w_sel_wait  = '0;
    case (cs_in)
      8'b1000_0000: w_sel_wait = 8'(CTRL_WAIT);
      8'b0100_0000: w_sel_wait = 8'(GFX_WAIT);
      8'b0010_0000: w_sel_wait = 8'(IO_WAIT);
      8'b0001_0000: w_sel_wait = 8'(CTRL_WAIT);
      8'b0000_1000,
      8'b0000_0100: w_sel_wait = 8'(RAM_WAIT);
      8'b0000_0010: w_sel_wait = 8'(ROM_WAIT);
      default:      w_region_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_tmo   <= '0;
      r_is_io <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      r_tmo   <= w_tmo_next;
      r_is_io <= w_is_io_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_wait_next  = r_wait;
    w_tmo_next   = r_tmo;
    w_is_io_next = r_is_io;
    case (r_state)
      S_IDLE: begin
        w_wait_next = '0;
        w_tmo_next  = '0;
        if (w_start) begin
          w_next     = S_DECODE;
          // The start edge itself counts toward the timeout.
          w_tmo_next = 8'd1;
        end
      end
      S_DECODE: begin
        w_tmo_next = r_tmo + 8'd1;
        if (as_n) begin
          w_next = S_IDLE;
        end else if (w_timeout || !w_region_ok) begin
          w_next = S_FAULT;
        end else if (w_sel_wait == '0) begin
          w_next = S_ACK;
        end else begin
          w_next       = S_WAIT;
          w_wait_next  = w_sel_wait;
          w_is_io_next = cs_in[5];
        end
      end
      S_WAIT: begin
        w_tmo_next = r_tmo + 8'd1;
        if (as_n) begin
          w_next = S_IDLE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end else if (r_wait > 8'd1) begin
          w_wait_next = r_wait - 8'd1;
        end else if (!r_is_io || !io_ready_n) begin
          w_next = S_ACK;
        end
      end
      S_ACK, S_FAULT: begin
        if (as_n) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign map_enable = (r_state == S_DECODE) || (r_state == S_WAIT) || (r_state == S_ACK);
  assign dtack_n    = (r_state != S_ACK);
  assign berr_n     = (r_state != S_FAULT);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomized and directed bench for bus_cycle_ctrl against an edge-count model.
module tb_bus_cycle_ctrl;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       as_n = 1'b1;
  logic       uds_n = 1'b1;
  logic       lds_n = 1'b1;
  logic [7:0] cs_in = '0;
  logic       io_ready_n = 1'b1;
  logic       map_enable, dtack_n, berr_n, busy;

  int n_checks = 0;
  int n_errors = 0;

  bus_cycle_ctrl #(
    .ROM_WAIT(2), .RAM_WAIT(1), .IO_WAIT(4), .GFX_WAIT(3), .CTRL_WAIT(0), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .cs_in(cs_in), .io_ready_n(io_ready_n), .map_enable(map_enable),
    .dtack_n(dtack_n), .berr_n(berr_n), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a cycle is tracked by the number of edges k since the start edge.
  // Result 0 = pending, 1 = acknowledged, 2 = bus error.
  int m_wait_tab [8] = '{-1, 2, 1, 1, 0, 4, 3, 0};
  logic m_active = 1'b0;
  int   m_k = 0, m_res = 0, m_w = 0;
  logic m_io = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    int kn;
    int w;
    if (reset) begin
      m_active <= 1'b0;
      m_res    <= 0;
      m_k      <= 0;
    end else if (!m_active) begin
      if (!as_n && (!uds_n || !lds_n)) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_res    <= 0;
      end
    end else begin
      kn = m_k + 1;
      m_k <= kn;
      if (as_n) begin
        m_active <= 1'b0;
        m_res    <= 0;
      end else if (m_res != 0) begin
        m_res <= m_res;
      end else if (kn == TIMEOUT - 1) begin
        m_res <= 2;
      end else if (kn == 1) begin
        if ($countones(cs_in) != 1 || cs_in[0]) begin
          m_res <= 2;
        end else begin
          w = 0;
          for (int i = 1; i < 8; i++) if (cs_in[i]) w = m_wait_tab[i];
          m_w  <= w;
          m_io <= cs_in[5];
          if (w == 0) m_res <= 1;
        end
      end else if (kn >= 1 + m_w && (!m_io || !io_ready_n)) begin
        m_res <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("busy", int'(busy), int'(m_active));
      check("dtack_n", int'(dtack_n), int'(!(m_active && m_res == 1)));
      check("berr_n", int'(berr_n), int'(!(m_active && m_res == 2)));
      check("map_enable", int'(map_enable), int'(m_active && m_res != 2));
    end
  end

  // Start a cycle, report which edge after E0 terminated it (1=dtack, 2=berr),
  // then release the strobe and confirm the bus goes quiet.
  task automatic directed(input string name, input logic [7:0] cs, input int io_at,
                          input int exp_kind, input int exp_edge);
    int got_kind = 0;
    int got_edge = -1;
    @(negedge clk);
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b1; cs_in = cs;
    io_ready_n = (io_at <= 0) ? 1'b0 : 1'b1;
    for (int j = 0; j < 100 && got_kind == 0; j++) begin
      @(posedge clk); #1;
      if (!dtack_n) got_kind = 1;
      else if (!berr_n) got_kind = 2;
      if (got_kind != 0) got_edge = j;
      @(negedge clk);
      io_ready_n = (j + 1 >= io_at) ? 1'b0 : 1'b1;
    end
    check({name, "_kind"}, got_kind, exp_kind);
    check({name, "_edge"}, got_edge, exp_edge);
    repeat (2) @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; io_ready_n = 1'b1;
    @(posedge clk); #1;
    check({name, "_rel_busy"}, int'(busy), 0);
    check({name, "_rel_map"}, int'(map_enable), 0);
    check({name, "_rel_term"}, int'(dtack_n & berr_n), 1);
  endtask

  function automatic logic [7:0] pick_cs();
    int r = $urandom_range(0, 11);
    if (r <= 6) return 8'(1 << (r + 1));
    if (r == 7) return 8'h00;
    if (r == 8) return 8'h01;
    if (r == 11) return 8'h20;
    return 8'($urandom);
  endfunction

  initial begin
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_dtack", int'(dtack_n), 1);
    check("reset_berr", int'(berr_n), 1);
    check("reset_map", int'(map_enable), 0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    directed("rom",    8'b0000_0010, 1000, 1, 3);
    directed("ram",    8'b0000_1000, 1000, 1, 2);
    directed("ctrl",   8'b1000_0000, 1000, 1, 1);
    directed("undef",  8'b0000_0000, 1000, 2, 1);
    directed("unmap",  8'b0000_0001, 1000, 2, 1);
    directed("io_hs",  8'b0010_0000, 8,    1, 8);
    directed("io_tmo", 8'b0010_0000, 1000, 2, TIMEOUT - 1);
    directed("multi",  8'b0000_1100, 1000, 2, 1);

    // GFX cycle aborted during wait states.
    @(negedge clk); as_n = 1'b0; lds_n = 1'b0; cs_in = 8'b0100_0000;
    repeat (3) @(posedge clk);
    @(negedge clk); as_n = 1'b1; lds_n = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", int'(busy), 0);
    check("abort_term", int'(dtack_n & berr_n), 1);

    // Reset pulsed while acknowledging a RAM cycle.
    @(negedge clk); as_n = 1'b0; uds_n = 1'b0; cs_in = 8'b0000_0100;
    repeat (3) @(posedge clk); #1;
    check("pre_rst_dtack", int'(dtack_n), 0);
    #1 reset = 1'b1; as_n = 1'b1; uds_n = 1'b1;
    #1;
    check("rst_dtack", int'(dtack_n), 1);
    check("rst_map", int'(map_enable), 0);
    check("rst_busy", int'(busy), 0);
    #1 reset = 1'b0;
    directed("ram_after_rst", 8'b0000_0100, 1000, 1, 2);

    for (int t = 0; t < 300; t++) begin
      int gap = $urandom_range(1, 3);
      int len;
      int v;
      logic long_txn;
      long_txn = ($urandom_range(0, 9) == 0);
      len = long_txn ? $urandom_range(60, 70) : $urandom_range(1, 12);
      repeat (gap) begin
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'($urandom); lds_n = 1'($urandom);
        cs_in = pick_cs(); io_ready_n = 1'($urandom);
      end
      v = $urandom_range(0, 9);
      {uds_n, lds_n} = (v == 0) ? 2'b11 : (v < 4) ? 2'b01 : (v < 7) ? 2'b10 : 2'b00;
      if (long_txn) cs_in = 8'b0010_0000;
      repeat (len) begin
        @(negedge clk);
        as_n = 1'b0;
        if (!long_txn) cs_in = pick_cs();
        io_ready_n = long_txn ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clk); as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
